hdmi_mode_sequencer: RTL
========================

Name: hdmi_mode_sequencer

Overview:
- Sits directly upstream of the HDMI PAL/NTSC output selector.
- Takes the VDP's requested video standard and drives the selector's pal_mode and hdmi_reset.
- Switches standard only at a frame boundary, blanks video around the switch, and holds the TMDS generators in reset for a defined window.
- Purpose: the sink sees a clean re-sync rather than a torn frame.

Parameters:
- RESET_CYCLES, 16: clk_pixel cycles hdmi_reset is held asserted per switch (1..255).
- SETTLE_FRAMES, 2: whole frames blank stays asserted after reset release (1..15).
- TIMEOUT_CYCLES, 600000: maximum wait for a frame boundary before switching anyway (needs a 20-bit counter; exceeds one PAL frame of 864x625 = 540000 cycles).

Ports:
- clk_pixel  in  1  pixel clock; all logic in this domain.
- reset_n  in  1  asynchronous active-low reset.
- pal_mode_req  in  1  requested standard (1 = PAL); may be asynchronous; passes a 2-flop synchronizer.
- cx  in  12  current pixel X from the output selector.
- cy  in  11  current line Y from the output selector.
- pal_mode  out  1  standard select to the output selector and serializer.
- hdmi_reset  out  1  active-high reset to both TMDS generators.
- blank  out  1  forces upstream rgb to 0 while high.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Frame boundary (fb): the single cycle where cx==0 and cy==0; combinational from the inputs.
- Synchronizer: req_s is the second flop of the synchronizer; both flops reset to 0.
- Reset values (async on reset_n low): state=HOLD, cnt=0, pal_mode=0, hdmi_reset=1, blank=1, busy=1.
  - Power-up therefore runs HOLD then SETTLE before IDLE.
- IDLE:
  - Outputs: hdmi_reset=0, blank=0, busy=0.
  - If req_s != pal_mode: go to WAIT next cycle, clear cnt.
- WAIT:
  - Outputs: blank=1, busy=1; cnt increments each cycle.
  - On fb, or cnt==TIMEOUT_CYCLES-1: go to HOLD, load pal_mode<=req_s, clear cnt. Set timeout_hit if the exit was by timeout.
  - If req_s reverts to equal pal_mode before exit: return to IDLE; blank drops the following cycle.
- HOLD:
  - Outputs: hdmi_reset=1, blank=1.
  - cnt counts 0..RESET_CYCLES-1, so hdmi_reset is high for exactly RESET_CYCLES cycles after entry.
  - Then go to SETTLE, clear the frame counter.
- SETTLE:
  - Outputs: hdmi_reset=0, blank=1.
  - Frame counter increments on each fb.
  - When it reaches SETTLE_FRAMES, go to IDLE the next cycle.
  - fb in the first cycle after reset release counts.
- Requests during HOLD/SETTLE: not sampled. On return to IDLE a mismatch starts a new sequence the next cycle; no request is lost, since the level is compared, not an edge.
- pal_mode changes only on the WAIT->HOLD transition, never elsewhere.
- All outputs are registered; no combinational path from input to output.
- Latency: req change to WAIT entry = 3 clk_pixel cycles (2 sync flops + 1 state register).
- reset_n asserted mid-sequence: immediate return to the reset values above; pal_mode returns to 0.

Optional Feature:
- Macro: HDMI_MODE_SEQ_STATUS_EN.
- Defined:
  - Adds output switch_count[7:0]: increments on each WAIT->HOLD transition, saturates at 255, resets to 0.
  - Adds output timeout_hit[0:0]: sticky, set when WAIT exits by timeout, cleared only by reset_n.
- Undefined: neither port exists; no timeout or count logic beyond the WAIT counter.

Test Plan:
- Reset release with pal_mode_req=0, fb every 1000 cycles:
  - hdmi_reset high exactly 16 cycles after reset_n rises.
  - blank falls after the 2nd fb; busy=0; pal_mode=0.
- In IDLE, raise pal_mode_req at cycle T; fb at T+500:
  - busy rises at T+3.
  - pal_mode=1 and hdmi_reset=1 on cycle T+501, held 16 cycles.
  - blank low after 2 further fbs.
- Raise req, hold cx/cy nonzero (no fb):
  - HOLD entered after 600000 WAIT cycles.
  - timeout_hit=1 with STATUS_EN.
- Pulse req high for 10 cycles during WAIT before any fb:
  - Return to IDLE; pal_mode stays 0; switch_count unchanged.
- Toggle req 0->1 during SETTLE:
  - Second sequence starts 1 cycle after IDLE entry.
  - pal_mode ends at 1; switch_count=2 (excluding power-up).
- Assert reset_n mid-HOLD with pal_mode=1:
  - All outputs immediately at reset values; pal_mode=0.
  - Full power-up sequence repeats.

Source files
------------

// File: rtl/hdmi_mode_sequencer.sv
// rtl/hdmi_mode_sequencer.sv - frame-aligned PAL/NTSC switch sequencer ahead of the HDMI output selector
//
// Ports:
//   clk_pixel     in   pixel clock; every register lives in this domain
//   reset_n       in   asynchronous active-low reset
//   pal_mode_req  in   requested standard from the VDP (1 = PAL); may be asynchronous
//   cx, cy        in   current pixel X / line Y from the output selector
//   pal_mode      out  standard select to the output selector and serializer
//   hdmi_reset    out  active-high reset to both TMDS generators
//   blank         out  forces upstream rgb to 0 while high
//   busy          out  high whenever the sequencer is not idle
//   switch_count  out  (HDMI_MODE_SEQ_STATUS_EN only) saturating count of standard switches
//   timeout_hit   out  (HDMI_MODE_SEQ_STATUS_EN only) sticky: a switch was forced by timeout
//
// Optional status outputs are enabled by defining HDMI_MODE_SEQ_STATUS_EN.

module hdmi_mode_sequencer #(
   parameter int unsigned RESET_CYCLES   = 16,
   parameter int unsigned SETTLE_FRAMES  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 600000
) (
   input  logic        clk_pixel,
   input  logic        reset_n,
   input  logic        pal_mode_req,
   input  logic [11:0] cx,
   input  logic [10:0] cy,
   output logic        pal_mode,
   output logic        hdmi_reset,
   output logic        blank,
   output logic        busy
`ifdef HDMI_MODE_SEQ_STATUS_EN
   ,
   output logic [7:0]  switch_count,
   output logic [0:0]  timeout_hit
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_HOLD,
      S_SETTLE
   } state_t;

   localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);
   localparam logic [19:0] HOLD_LAST    = 20'(RESET_CYCLES - 1);
   localparam logic [3:0]  SETTLE_LAST  = 4'(SETTLE_FRAMES - 1);

   state_t      state;
   logic [19:0] cnt;
   logic [3:0]  frame_cnt;
   logic        req_meta;
   logic        req_s;
   logic        fb;
   logic        wait_done;

   assign fb        = (cx == 12'd0) && (cy == 11'd0);
   assign wait_done = fb || (cnt == TIMEOUT_LAST);

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         req_meta <= 1'b0;
         req_s    <= 1'b0;
      end else begin
         req_meta <= pal_mode_req;
         req_s    <= req_meta;
      end
   end

   // Power-up enters HOLD directly so the TMDS generators start from a clean reset.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_HOLD;
         cnt        <= '0;
         frame_cnt  <= '0;
         pal_mode   <= 1'b0;
         hdmi_reset <= 1'b1;
         blank      <= 1'b1;
         busy       <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               // Level compare: a request that arrived during HOLD/SETTLE is picked up here.
               if (req_s != pal_mode) begin
                  state <= S_WAIT;
                  cnt   <= '0;
                  blank <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            S_WAIT: begin
               // A reverted request wins over a simultaneous boundary: nothing to switch.
               if (req_s == pal_mode) begin
                  state <= S_IDLE;
                  blank <= 1'b0;
                  busy  <= 1'b0;
               end else if (wait_done) begin
                  state      <= S_HOLD;
                  pal_mode   <= req_s;
                  cnt        <= '0;
                  hdmi_reset <= 1'b1;
               end else begin
                  cnt <= cnt + 20'd1;
               end
            end
            S_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  state      <= S_SETTLE;
                  hdmi_reset <= 1'b0;
                  cnt        <= '0;
                  frame_cnt  <= '0;
               end else begin
                  cnt <= cnt + 20'd1;
               end
            end
            S_SETTLE: begin
               // The boundary that completes the last settle frame releases blank on the next cycle.
               if (fb) begin
                  if (frame_cnt == SETTLE_LAST) begin
                     state <= S_IDLE;
                     blank <= 1'b0;
                     busy  <= 1'b0;
                  end else begin
                     frame_cnt <= frame_cnt + 4'd1;
                  end
               end
            end
            default: begin
               state <= S_HOLD;
            end
         endcase
      end
   end

`ifdef HDMI_MODE_SEQ_STATUS_EN
   logic switch_evt;

   assign switch_evt = (state == S_WAIT) && (req_s != pal_mode) && wait_done;

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         switch_count <= 8'd0;
         timeout_hit  <= 1'b0;
      end else if (switch_evt) begin
         if (switch_count != 8'hFF) begin
            switch_count <= switch_count + 8'd1;
         end
         if (!fb) begin
            timeout_hit <= 1'b1;
         end
      end
   end
`endif

endmodule
